bcd_scan_driver: RTL and testbench
==================================

BCD_SCAN_DRIVER -- requirements
Module: bcd_scan_driver

Interface
REQ-001 Parameter PRESCALE, default 4: clock cycles each digit is displayed; legal range 2..65535.
REQ-002 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-low reset.
REQ-004 Port digits_in  input  16  four BCD digits from the upstream mod-10 counter chain; [3:0]=digit0 (least significant), [15:12]=digit3.
REQ-005 Port load  input  1  one-cycle request to capture digits_in.
REQ-006 Port blank_lz  input  1  leading-zero blanking enable; sampled live, not latched.
REQ-007 Port clr_ovr  input  1  clears the overrun flag.
REQ-008 Port seg_n  output  7  active-low segments; bit0=a through bit6=g; registered.
REQ-009 Port an_n  output  4  active-low one-hot digit enable; an_n[i]=0 selects digit i; registered.
REQ-010 Port upd_ack  output  1  one-cycle pulse when a pending value reaches the display register.
REQ-011 Port overrun  output  1  sticky flag: pending value overwritten before it was displayed.

Function
REQ-012 Prescaler counts 0..PRESCALE-1 and wraps to 0; its terminal cycle is the cycle where it equals PRESCALE-1.
REQ-013 Scan index 0..3 advances by 1 on each prescaler terminal cycle and wraps from 3 to 0.
REQ-014 Frame boundary is the prescaler terminal cycle with scan index 3.
REQ-015 When load=1, digits_in is written to the pending register and the pending flag is set.
REQ-016 When load=1 with pending already set, outside a frame boundary, the pending register is overwritten and overrun is set.
REQ-017 At a frame boundary with pending set, the display register takes the old pending value, and upd_ack is 1 in the following cycle only.
REQ-018 If load=1 on that same boundary cycle, the new digits become pending, pending stays set, and overrun does not change.
REQ-019 At a frame boundary with pending clear, the display register holds its value and upd_ack stays 0.
REQ-020 A load on a boundary cycle with pending clear becomes pending and transfers at the next boundary.
REQ-021 clr_ovr=1 clears overrun; when it coincides with an overrun-setting event, the set wins.
REQ-022 an_n equals the one-hot-low of the scan index, delayed one cycle.
REQ-023 seg_n shows the decode of the selected display digit, delayed one cycle.
REQ-024 Segment decode for digits 0..9 uses the standard 7-segment patterns; 0 gives 7'b1000000 and 8 gives 7'b0000000.
REQ-025 Digit values 10..15 display a dash, seg_n=7'b0111111.
REQ-026 With blank_lz=1, digit i (i=1..3) shows seg_n=7'b1111111 when it and all higher digits are 0.
REQ-027 Digit 0 is never blanked, and a blanked position still has its an_n bit driven low.
REQ-028 Display latency from accepted load to visible digit is at most 4*PRESCALE+1 cycles plus the wait for the boundary.

Reset
REQ-029 While rst=0 the block holds: prescaler 0, index 0, display, pending and pending flag 0, upd_ack 0, overrun 0, an_n=4'b1111, seg_n=7'b1111111.
REQ-030 On the first rising edge after rst deasserts, the outputs become an_n=4'b1110 and seg_n=7'b1000000.
REQ-031 Reset asserted mid-frame discards any pending value without an upd_ack pulse and with no glitch on the outputs after the reset state is reached.

Structure
REQ-032 Shared package seg7_pkg holds: NUM_DIGITS=4, SEG_BLANK=7'b1111111, SEG_DASH=7'b0111111, and the 10-entry digit-to-segment constant table.
REQ-033 Sub-module bcd_to_seg7 is purely combinational: 4-bit digit plus blank input in, 7-bit seg_n pattern out.
REQ-034 bcd_to_seg7 is instantiated once, after the digit mux; the registered outputs and control logic stay in bcd_scan_driver.

Verification (PRESCALE=4)
REQ-035 Reset release -> an_n steps 1110, 1101, 1011, 0111 every 4 cycles and repeats; seg_n=7'b1000000 throughout.
REQ-036 load with digits_in=16'h1234 mid-frame -> one upd_ack pulse the cycle after the next boundary; digit3 then shows 1 (7'b1111001) and digit0 shows 4 (7'b0011001).
REQ-037 Two loads, 16'h0005 then 16'h0007, before one boundary -> overrun=1; displays 0007; clr_ovr then gives overrun=0.
REQ-038 blank_lz=1 with 16'h0050 displayed -> digits 3 and 2 show 7'b1111111, digit1 shows 5, digit0 shows 0.
REQ-039 load on the exact boundary cycle with pending 16'h0001, new value 16'h0002 -> 0001 displays now and 0002 displays at the next boundary; two upd_ack pulses; overrun stays 0.
REQ-040 digits_in=16'h000C loaded -> digit0 shows dash 7'b0111111; rst pulsed mid-frame -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the four-digit seven-segment scan driver.
package seg7_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  // Active-low patterns, bit0=a .. bit6=g, indexed by digit value
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD digit to active-low segment decoder with blanking.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg_n
);
  always_comb seg_n = blank ? SEG_BLANK : (digit > 4'd9) ? SEG_DASH : SEG_TABLE[digit];
endmodule

// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver: time-multiplexed 4-digit display driver with frame-synchronous
// double-buffered updates, leading-zero blanking and a sticky overrun flag.
module bcd_scan_driver
  import seg7_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic        load,
  input  logic        blank_lz,
  input  logic        clr_ovr,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        upd_ack,
  output logic        overrun
);
  localparam logic [15:0] LAST = 16'(PRESCALE - 1);
  logic [15:0] presc_q, presc_d, pend_q, pend_d, disp_q, disp_d;
  logic [1:0] idx_q, idx_d;
  logic pend_v_q, pend_v_d, ack_q, ack_d, ovr_q, ovr_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic term, frame, xfer, blank;
  logic [3:0] digit;
  logic [NUM_DIGITS-1:0] nz;
  always_comb begin
    term = presc_q == LAST;
    frame = term && idx_q == 2'd3;
    xfer = frame && pend_v_q;
    presc_d = term ? '0 : presc_q + 16'd1;
    idx_d = term ? idx_q + 2'd1 : idx_q;
    disp_d = xfer ? pend_q : disp_q;
    pend_d = load ? digits_in : pend_q;
    pend_v_d = xfer ? load : (pend_v_q | load);
    ack_d = xfer;
    // A load landing on the transfer cycle refills the buffer legitimately
    ovr_d = (load && pend_v_q && !frame) ? 1'b1 : clr_ovr ? 1'b0 : ovr_q;
    digit = disp_q[{idx_q, 2'b00} +: 4];
    for (int i = 0; i < NUM_DIGITS; i++) nz[i] = |disp_q[4*i +: 4];
    blank = blank_lz && idx_q != 2'd0 && (nz >> idx_q) == 4'd0;
    an_d = ~(4'd1 << idx_q);
  end
  bcd_to_seg7 u_dec (
    .digit(digit),
    .blank(blank),
    .seg_n(seg_d)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      idx_q <= '0;
      pend_q <= '0;
      disp_q <= '0;
      pend_v_q <= 1'b0;
      ack_q <= 1'b0;
      ovr_q <= 1'b0;
      an_q <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      presc_q <= presc_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      pend_v_q <= pend_v_d;
      ack_q <= ack_d;
      ovr_q <= ovr_d;
      an_q <= an_d;
      seg_q <= seg_d;
    end
  end
  assign seg_n = seg_q;
  assign an_n = an_q;
  assign upd_ack = ack_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_bcd_scan_driver.sv
// tb_bcd_scan_driver: table-driven and directed checks of bcd_scan_driver at PRESCALE=4.
module tb_bcd_scan_driver;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000,
                         S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000,
                         S8 = 7'b0000000, S9 = 7'b0010000, SB = 7'b1111111, SD = 7'b0111111;
  typedef struct packed {
    logic [15:0]     digits;
    logic            blank;
    logic [3:0][6:0] exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, load = 1'b0, blank_lz = 1'b0, clr_ovr = 1'b0;
  logic [15:0] digits_in = '0;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic upd_ack, overrun;
  int n = 0, pass_cnt = 0, total = 0;
  vec_t vecs [8];
  always #5 clk = ~clk;
  bcd_scan_driver #(.PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .load(load), .blank_lz(blank_lz),
    .clr_ovr(clr_ovr), .seg_n(seg_n), .an_n(an_n), .upd_ack(upd_ack), .overrun(overrun)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask
  task automatic go(input int k);
    while (n % 16 != k) step();
  endtask
  task automatic ld(input logic [15:0] v);
    digits_in = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask
  task automatic wait_xfer(input logic exp, input string nm);
    go(0);
    chk({nm, " ack"}, upd_ack, exp);
    step();
    chk({nm, " ack_end"}, upd_ack, 1'b0);
  endtask
  task automatic frame(input logic [3:0][6:0] e, input string nm);
    logic [3:0] ea;
    for (int i = 0; i < 4; i++) begin
      go(1 + 4 * i);
      ea = ~(4'd1 << i);
      chk($sformatf("%s an%0d", nm, i), an_n, ea);
      chk($sformatf("%s seg%0d", nm, i), seg_n, e[i]);
    end
  endtask
  initial begin
    logic [3:0] ea;
    vecs[0] = '{16'h1234, 1'b0, {S1, S2, S3, S4}};
    vecs[1] = '{16'h0050, 1'b1, {SB, SB, S5, S0}};
    vecs[2] = '{16'h000C, 1'b0, {S0, S0, S0, SD}};
    vecs[3] = '{16'h000C, 1'b1, {SB, SB, SB, SD}};
    vecs[4] = '{16'h9876, 1'b0, {S9, S8, S7, S6}};
    vecs[5] = '{16'h0000, 1'b1, {SB, SB, SB, S0}};
    vecs[6] = '{16'h0305, 1'b1, {SB, S3, S0, S5}};
    vecs[7] = '{16'hFA00, 1'b0, {SD, SD, S0, S0}};
    repeat (3) @(negedge clk);
    chk("rst an", an_n, 4'b1111);
    chk("rst seg", seg_n, SB);
    chk("rst ack", upd_ack, 1'b0);
    chk("rst ovr", overrun, 1'b0);
    @(negedge clk) rst = 1'b1;
    n = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      ea = ~(4'd1 << (((k - 1) / 4) % 4));
      chk($sformatf("scan an k%0d", k), an_n, ea);
      chk($sformatf("scan seg k%0d", k), seg_n, S0);
    end
    for (int v = 0; v < 8; v++) begin
      blank_lz = vecs[v].blank;
      go(5);
      ld(vecs[v].digits);
      chk($sformatf("vec%0d ovr", v), overrun, 1'b0);
      wait_xfer(1'b1, $sformatf("vec%0d", v));
      frame(vecs[v].exp, $sformatf("vec%0d", v));
    end
    blank_lz = 1'b0;
    go(3);
    ld(16'h0005);
    chk("ovr first", overrun, 1'b0);
    ld(16'h0007);
    chk("ovr second", overrun, 1'b1);
    wait_xfer(1'b1, "ovr");
    frame({S0, S0, S0, S7}, "ovr disp");
    chk("ovr sticky", overrun, 1'b1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("ovr clr", overrun, 1'b0);
    go(5);
    ld(16'h0008);
    digits_in = 16'h0009;
    load = 1'b1;
    clr_ovr = 1'b1;
    step();
    load = 1'b0;
    clr_ovr = 1'b0;
    chk("ovr set wins", overrun, 1'b1);
    wait_xfer(1'b1, "setwin");
    frame({S0, S0, S0, S9}, "setwin disp");
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("ovr clr2", overrun, 1'b0);
    go(8);
    ld(16'h0001);
    go(15);
    ld(16'h0002);
    chk("bnd ovr", overrun, 1'b0);
    wait_xfer(1'b1, "bnd1");
    frame({S0, S0, S0, S1}, "bnd1 disp");
    wait_xfer(1'b1, "bnd2");
    frame({S0, S0, S0, S2}, "bnd2 disp");
    chk("bnd ovr end", overrun, 1'b0);
    go(15);
    ld(16'h0003);
    wait_xfer(1'b0, "late");
    frame({S0, S0, S0, S2}, "late hold");
    wait_xfer(1'b1, "late xfer");
    frame({S0, S0, S0, S3}, "late disp");
    go(5);
    ld(16'h000C);
    ld(16'h000D);
    chk("pre-rst ovr", overrun, 1'b1);
    go(8);
    #2 rst = 1'b0;
    #1;
    chk("mid rst an", an_n, 4'b1111);
    chk("mid rst seg", seg_n, SB);
    chk("mid rst ovr", overrun, 1'b0);
    chk("mid rst ack", upd_ack, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst hold an", an_n, 4'b1111);
    chk("rst hold seg", seg_n, SB);
    @(negedge clk) rst = 1'b1;
    n = 0;
    step();
    chk("post rst an", an_n, 4'b1110);
    chk("post rst seg", seg_n, S0);
    go(0);
    chk("post rst no ack", upd_ack, 1'b0);
    step();
    chk("post rst seg0", seg_n, S0);
    chk("post rst ovr", overrun, 1'b0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
